draw_rect_char: RTL and testbench

//  Overlays one box of fixed-pitch text (8x16 px glyphs) on the VGA pixel stream, downstream of the filter output.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/signal_delay.sv | 32 +++
 rtl/draw_rect_char.sv | 133 +++++++++++++
 tb/tb_draw_rect_char.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and the VGA timing bundle used by the text overlay.
// Latency: none (types and constants only).
// Backpressure: none; the pixel stream never stalls.
package vga_pkg;

    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;

    // Fill colour for the non-glyph pixels of an opaque text box
    localparam logic [11:0] TEXT_BG_RGB = 12'h000;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        hblnk;
        logic        vsync;
        logic        vblnk;
    } timing_t;

    localparam int TIMING_W = $bits(timing_t);

endpackage

// File: rtl/signal_delay.sv
// Parametric shift register delaying a WIDTH-bit word by CLK_DEL clocks.
// Latency: exactly CLK_DEL clk.
// Backpressure: none; shifts every clock, sync reset clears every stage.
module signal_delay #(
    parameter int WIDTH   = 1,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [CLK_DEL];

    // Shift chain; reset flushes all stages so stale data never reaches dout
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CLK_DEL; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < CLK_DEL; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[CLK_DEL-1];

endmodule

// File: rtl/draw_rect_char.sv
// Overlays a fixed-pitch 8x16 text box on the VGA stream; optional opaque background via TEXT_BG_EN.
// Latency: exactly 3 clk from every *_in to its *_out.
// Backpressure: none; one pixel in and one pixel out every clock, no bubbles.
module draw_rect_char
    import vga_pkg::*;
#(
    parameter int          XPOS      = 16,
    parameter int          YPOS      = 8,
    parameter int          TEXT_COLS = 30,
    parameter int          TEXT_ROWS = 1,
    parameter logic [11:0] FG_RGB    = 12'hFFF
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [6:0]  char_code,
    input  logic [7:0]  char_line_pixels,
    output logic [7:0]  char_xy,
    output logic [3:0]  char_line,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    // Box bounds; right and bottom edges are exclusive
    localparam logic [11:0] X_LO = 12'(XPOS);
    localparam logic [11:0] X_HI = 12'(XPOS + CHAR_W * TEXT_COLS);
    localparam logic [11:0] Y_LO = 12'(YPOS);
    localparam logic [11:0] Y_HI = 12'(YPOS + CHAR_H * TEXT_ROWS);

    // char_code only addresses the external font ROM together with char_line
    logic unused_char_code;
    assign unused_char_code = ^char_code;

    logic [11:0] h12, v12;
    logic [10:0] hrel, vrel;
    logic        in_box_c;

    // Compare in 12 bits before subtracting so an underflowed hrel/vrel never counts as inside
    always_comb begin
        h12      = {1'b0, hcount_in};
        v12      = {1'b0, vcount_in};
        hrel     = hcount_in - 11'(XPOS);
        vrel     = vcount_in - 11'(YPOS);
        in_box_c = (h12 >= X_LO) && (h12 < X_HI) && (v12 >= Y_LO) && (v12 < Y_HI);
    end

    // S1: glyph index and glyph row for char_rom / font ROM; parked at 0 outside the box
    always_ff @(posedge pclk) begin
        if (rst) begin
            char_xy   <= '0;
            char_line <= '0;
        end else if (in_box_c) begin
            char_xy   <= 8'(32'(vrel[10:4]) * TEXT_COLS + 32'(hrel[10:3]));
            char_line <= vrel[3:0];
        end else begin
            char_xy   <= '0;
            char_line <= '0;
        end
    end

    // in_box / bit index: first stage is the S1 register, second lines up with the font ROM output
    logic       in_box_d2;
    logic [2:0] bit_idx_d2;

    signal_delay #(.WIDTH(4), .CLK_DEL(2)) u_box_dly (
        .clk  (pclk),
        .rst  (rst),
        .din  ({in_box_c, hrel[2:0]}),
        .dout ({in_box_d2, bit_idx_d2})
    );

    // Timing bundle and upstream pixel travel the full 3-clk pipeline together
    timing_t     timing_in, timing_d3;
    logic [11:0] rgb_d3;

    assign timing_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                         hblnk: hblnk_in, vsync: vsync_in, vblnk: vblnk_in};

    signal_delay #(.WIDTH(TIMING_W + 12), .CLK_DEL(3)) u_stream_dly (
        .clk  (pclk),
        .rst  (rst),
        .din  ({timing_in, rgb_in}),
        .dout ({timing_d3, rgb_d3})
    );

    // S3: select the glyph bit (MSB is leftmost pixel) while font data is valid
    logic in_box_d3, pix_d3;

    always_ff @(posedge pclk) begin
        if (rst) begin
            in_box_d3 <= 1'b0;
            pix_d3    <= 1'b0;
        end else begin
            in_box_d3 <= in_box_d2;
            pix_d3    <= char_line_pixels[3'd7 - bit_idx_d2];
        end
    end

    // Output mux: blanking wins, then glyph colour, then box background or pass-through
    always_comb begin
        rgb_out = rgb_d3;
        if (timing_d3.hblnk || timing_d3.vblnk) begin
            rgb_out = 12'h000;
        end else if (in_box_d3 && pix_d3) begin
            rgb_out = FG_RGB;
        end else if (in_box_d3) begin
`ifdef TEXT_BG_EN
            rgb_out = TEXT_BG_RGB;
`else
            rgb_out = rgb_d3;
`endif
        end
    end

    assign hcount_out = timing_d3.hcount;
    assign vcount_out = timing_d3.vcount;
    assign hsync_out  = timing_d3.hsync;
    assign hblnk_out  = timing_d3.hblnk;
    assign vsync_out  = timing_d3.vsync;
    assign vblnk_out  = timing_d3.vblnk;

endmodule

// File: tb/tb_draw_rect_char.sv
// Bench for draw_rect_char with a combinational char_rom model and a synchronous font model.
// Latency: expects every output 3 clk after its input, char_xy/char_line 1 clk after.
// Backpressure: none; the stream is driven one pixel per clock.
module tb_draw_rect_char;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [6:0]  char_code;
    logic [7:0]  char_line_pixels = '0;
    logic [7:0]  char_xy;
    logic [3:0]  char_line;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_out;

    int checks   = 0;
    int failures = 0;

    // 0: font returns font_const for every address; otherwise font_fn of the address
    logic [1:0] font_mode  = 2'd0;
    logic [7:0] font_const = 8'h00;

`ifdef TEXT_BG_EN
    localparam logic [11:0] BG_EXP = 12'h000;
`else
    localparam logic [11:0] BG_EXP = 12'h123;
`endif

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        hb;
        logic        vs;
        logic        vb;
        logic [11:0] rgb;
    } exp_t;

    exp_t q[$];

    always #5 pclk = ~pclk;

    draw_rect_char dut (
        .pclk             (pclk),
        .rst              (rst),
        .hcount_in        (hcount_in),
        .vcount_in        (vcount_in),
        .hsync_in         (hsync_in),
        .hblnk_in         (hblnk_in),
        .vsync_in         (vsync_in),
        .vblnk_in         (vblnk_in),
        .rgb_in           (rgb_in),
        .char_code        (char_code),
        .char_line_pixels (char_line_pixels),
        .char_xy          (char_xy),
        .char_line        (char_line),
        .hcount_out       (hcount_out),
        .vcount_out       (vcount_out),
        .hsync_out        (hsync_out),
        .hblnk_out        (hblnk_out),
        .vsync_out        (vsync_out),
        .vblnk_out        (vblnk_out),
        .rgb_out          (rgb_out)
    );

    function automatic logic [7:0] font_fn(input logic [6:0] code, input logic [3:0] line);
        logic [10:0] a;
        a = {code, line};
        return 8'((int'(a) * 37) ^ (int'(a) >> 3));
    endfunction

    // char_rom: combinational glyph code per index
    assign char_code = 7'(int'(char_xy) * 3 + 5);

    // font ROM: one clock of latency on {char_code, char_line}
    always @(posedge pclk)
        char_line_pixels <= (font_mode == 2'd0) ? font_const : font_fn(char_code, char_line);

    // Reference pixel for a box at (16,8), 30x1 glyphs, white foreground
    function automatic logic [11:0] ref_rgb(input int h, input int v, input logic hb,
                                            input logic vb, input logic [11:0] rgb);
        int         col, row, xy, line, bi;
        logic [6:0] code;
        logic [7:0] bits;
        if (hb || vb) return 12'h000;
        if (!(h >= 16 && h < 256 && v >= 8 && v < 24)) return rgb;
        col  = (h - 16) / 8;
        row  = (v - 8) / 16;
        xy   = row * 30 + col;
        code = 7'(xy * 3 + 5);
        line = (v - 8) % 16;
        bi   = 7 - ((h - 16) % 8);
        bits = (font_mode == 2'd0) ? font_const : font_fn(code, 4'(line));
        if (bits[bi]) return 12'hFFF;
`ifdef TEXT_BG_EN
        return 12'h000;
`else
        return rgb;
`endif
    endfunction

    task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hs,
                         input logic hb, input logic vs, input logic vb, input logic [11:0] rgb);
        hcount_in = h;
        vcount_in = v;
        hsync_in  = hs;
        hblnk_in  = hb;
        vsync_in  = vs;
        vblnk_in  = vb;
        rgb_in    = rgb;
    endtask

    task automatic step;
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(11'($urandom), 11'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 12'($urandom));
            step();
        end
        checks++;
        if (rgb_out !== 12'h000) begin
            failures++;
            $display("FAIL reset_rgb got=%h want=000", rgb_out);
        end
        checks++;
        if ({hcount_out, vcount_out} !== 22'd0) begin
            failures++;
            $display("FAIL reset_counts got=%0d,%0d want=0,0", hcount_out, vcount_out);
        end
        checks++;
        if ({hsync_out, hblnk_out, vsync_out, vblnk_out} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes got=%b want=0000",
                     {hsync_out, hblnk_out, vsync_out, vblnk_out});
        end
        checks++;
        if ({char_xy, char_line} !== 12'd0) begin
            failures++;
            $display("FAIL reset_char got=%0d,%0d want=0,0", char_xy, char_line);
        end
        // Release: first pixel emerges exactly 3 clk later
        drive(11'd0, 11'd100, 1'b0, 1'b0, 1'b0, 1'b0, 12'hABC);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (rgb_out !== ((i == 3) ? 12'hABC : 12'h000)) begin
                failures++;
                $display("FAIL release_rgb clk=%0d got=%h want=%h", i, rgb_out,
                         (i == 3) ? 12'hABC : 12'h000);
            end
        end
        checks++;
        if (vcount_out !== 11'd100) begin
            failures++;
            $display("FAIL release_vcount got=%0d want=100", vcount_out);
        end
    endtask

    task automatic test_char_addr;
        logic [10:0] hv [4] = '{11'd16, 11'd248, 11'd100, 11'd255};
        logic [10:0] vv [4] = '{11'd8,  11'd23,  11'd13,  11'd8};
        logic [7:0]  xe [4] = '{8'd0,   8'd29,   8'd10,   8'd29};
        logic [3:0]  le [4] = '{4'd0,   4'd15,   4'd5,    4'd0};
        for (int i = 0; i < 4; i++) begin
            drive(hv[i], vv[i], 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
            step();
            checks++;
            if (char_xy !== xe[i]) begin
                failures++;
                $display("FAIL char_xy h=%0d v=%0d got=%0d want=%0d", hv[i], vv[i], char_xy, xe[i]);
            end
            checks++;
            if (char_line !== le[i]) begin
                failures++;
                $display("FAIL char_line h=%0d v=%0d got=%0d want=%0d", hv[i], vv[i], char_line, le[i]);
            end
        end
    endtask

    task automatic test_glyph;
        logic [10:0] hv [9] = '{11'd15, 11'd16, 11'd17, 11'd20, 11'd22, 11'd23, 11'd24, 11'd255, 11'd256};
        logic [11:0] re [9] = '{12'h123, 12'hFFF, BG_EXP, BG_EXP, BG_EXP, 12'hFFF, 12'hFFF, 12'hFFF, 12'h123};
        font_mode  = 2'd0;
        font_const = 8'b1000_0001;
        for (int i = 0; i < 11; i++) begin
            if (i < 9) drive(hv[i], 11'd10, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
            step();
            if (i >= 2) begin
                checks++;
                if (rgb_out !== re[i-2]) begin
                    failures++;
                    $display("FAIL glyph_rgb h=%0d got=%h want=%h", hv[i-2], rgb_out, re[i-2]);
                end
            end
        end
    endtask

    task automatic test_edges;
        logic [10:0] hv [6] = '{11'd15, 11'd256, 11'd100, 11'd100, 11'd255, 11'd16};
        logic [10:0] vv [6] = '{11'd10, 11'd10,  11'd7,   11'd24,  11'd23,  11'd8};
        logic [11:0] re [6] = '{12'h456, 12'h456, 12'h456, 12'h456, 12'hFFF, 12'hFFF};
        logic [7:0]  xe [6] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd29, 8'd0};
        logic [3:0]  le [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 4'd0};
        font_mode  = 2'd0;
        font_const = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) drive(hv[i], vv[i], 1'b0, 1'b0, 1'b0, 1'b0, 12'h456);
            step();
            if (i < 6) begin
                checks++;
                if ({char_xy, char_line} !== {xe[i], le[i]}) begin
                    failures++;
                    $display("FAIL edge_char h=%0d v=%0d got=%0d,%0d want=%0d,%0d",
                             hv[i], vv[i], char_xy, char_line, xe[i], le[i]);
                end
            end
            if (i >= 2) begin
                checks++;
                if (rgb_out !== re[i-2]) begin
                    failures++;
                    $display("FAIL edge_rgb h=%0d v=%0d got=%h want=%h", hv[i-2], vv[i-2], rgb_out, re[i-2]);
                end
            end
        end
    endtask

    task automatic test_blank;
        logic        hb [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        vb [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        hs [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [11:0] re [5] = '{12'h000, 12'h000, 12'hFFF, 12'h000, 12'hFFF};
        font_mode  = 2'd0;
        font_const = 8'hFF;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) drive(11'(20 + i), 11'd10, hs[i], hb[i], 1'b0, vb[i], 12'h777);
            step();
            if (i >= 2) begin
                checks++;
                if (rgb_out !== re[i-2]) begin
                    failures++;
                    $display("FAIL blank_rgb idx=%0d got=%h want=%h", i - 2, rgb_out, re[i-2]);
                end
                checks++;
                if ({hsync_out, hblnk_out, vblnk_out} !== {hs[i-2], hb[i-2], vb[i-2]}) begin
                    failures++;
                    $display("FAIL blank_strobes idx=%0d got=%b want=%b", i - 2,
                             {hsync_out, hblnk_out, vblnk_out}, {hs[i-2], hb[i-2], vb[i-2]});
                end
            end
        end
    endtask

    task automatic test_midreset;
        exp_t e;
        font_mode = 2'd1;
        q.delete();
        for (int h = 90; h <= 110; h++) begin
            drive(11'(h), 11'd10, 1'b0, 1'b0, 1'b0, 1'b0, 12'(h * 5));
            rst = (h == 100);
            if (rst) begin
                foreach (q[k]) q[k] = '0;
                e = '0;
            end else begin
                e = '{h: 11'(h), v: 11'd10, hs: 1'b0, hb: 1'b0, vs: 1'b0, vb: 1'b0,
                      rgb: ref_rgb(h, 10, 1'b0, 1'b0, 12'(h * 5))};
            end
            q.push_back(e);
            step();
            if (q.size() == 3) begin
                e = q.pop_front();
                checks++;
                if ({hcount_out, rgb_out} !== {e.h, e.rgb}) begin
                    failures++;
                    $display("FAIL midreset h_out=%0d rgb=%h want h=%0d rgb=%h",
                             hcount_out, rgb_out, e.h, e.rgb);
                end
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            e = q.pop_front();
            checks++;
            if ({hcount_out, rgb_out} !== {e.h, e.rgb}) begin
                failures++;
                $display("FAIL midreset_drain h_out=%0d rgb=%h want h=%0d rgb=%h",
                         hcount_out, rgb_out, e.h, e.rgb);
            end
        end
    endtask

    task automatic test_frame;
        exp_t e, o, first_bad_e, first_bad_o;
        int   bad;
        int   v;
        logic hb, hs, vb, vs;
        font_mode = 2'd1;
        bad = 0;
        first_bad_e = '0;
        first_bad_o = '0;
        q.delete();
        // Top 28 lines of an 800x600 frame (covers the whole box) plus two vertical-blank lines
        for (int li = 0; li < 32; li++) begin
            v  = (li < 28) ? li : 572 + li;
            if (li >= 30) break;
            vb = (v >= 600);
            vs = (v == 601);
            for (int h = 0; h < 1056; h++) begin
                hb = (h >= 800);
                hs = (h >= 840) && (h < 968);
                drive(11'(h), 11'(v), hs, hb, vs, vb, 12'(h * 7 + v * 13));
                e = '{h: 11'(h), v: 11'(v), hs: hs, hb: hb, vs: vs, vb: vb,
                      rgb: ref_rgb(h, v, hb, vb, 12'(h * 7 + v * 13))};
                q.push_back(e);
                step();
                if (q.size() == 3) begin
                    e = q.pop_front();
                    o = '{h: hcount_out, v: vcount_out, hs: hsync_out, hb: hblnk_out,
                          vs: vsync_out, vb: vblnk_out, rgb: rgb_out};
                    if (o !== e) begin
                        if (bad == 0) begin
                            first_bad_e = e;
                            first_bad_o = o;
                        end
                        bad++;
                    end
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            step();
            e = q.pop_front();
            o = '{h: hcount_out, v: vcount_out, hs: hsync_out, hb: hblnk_out,
                  vs: vsync_out, vb: vblnk_out, rgb: rgb_out};
            if (o !== e) begin
                if (bad == 0) begin
                    first_bad_e = e;
                    first_bad_o = o;
                end
                bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL frame_scoreboard mismatches=%0d want=0 first got=%h want=%h",
                     bad, first_bad_o, first_bad_e);
        end
    endtask

    initial begin
        test_reset();
        test_char_addr();
        test_glyph();
        test_edges();
        test_blank();
        test_midreset();
        test_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
